// File: rtl/seq_state_reg.sv
// Overlapping "101" serial detector: registered 2-bit state, Moore detect, one-cycle entry pulse, saturating hit counter.
// One-cycle latency from an accepted bit to state/detect/pulse; in_valid low holds the state, load overrides in_valid.
module seq_state_reg #(
  parameter int         CNT_W       = 8,
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             load,
  input  logic [1:0]       load_state,
  input  logic             clr_count,
  output logic [1:0]       currstate,
  output logic [1:0]       nextstate,
  output logic             detect,
  output logic             det_pulse,
  output logic [CNT_W-1:0] det_count
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic hit;

  always_comb begin
    nextstate = S0;
    case (currstate)
      S0:      nextstate = in ? S1 : S0;
      S1:      nextstate = in ? S1 : S2;
      S2:      nextstate = in ? S3 : S0;
      S3:      nextstate = in ? S1 : S2;
      default: nextstate = S0;
    endcase
  end

  // A loaded S3 is not a detection; only a stepped entry into S3 counts.
  assign hit    = in_valid && !load && (nextstate == S3) && (currstate != S3);
  assign detect = (currstate == S3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      currstate <= RESET_STATE;
      det_pulse <= 1'b0;
      det_count <= '0;
    end else begin
      if (load) begin
        currstate <= load_state;
      end else if (in_valid) begin
        currstate <= nextstate;
      end
      det_pulse <= hit;
      // Clear wins over a same-edge detection; the pulse still fires.
      if (clr_count) begin
        det_count <= '0;
      end else if (hit && (det_count != CNT_MAX)) begin
        det_count <= det_count + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/seq_state_reg.md
Name: seq_state_reg

Overview:
- Clocked stage directly downstream of the 2-bit next-state function (`in`, `currstate` -> `nextstate`).
- Registers the 2-bit state and feeds it back as `currstate`; the transition table below is computed inside this block.
- Adds input-valid gating, a forced state load, Moore detect outputs, and a saturating detection counter.
- Together these form a complete overlapping "101" serial sequence detector for the top level.

Parameters:
- CNT_W, 8, width of the detection counter.
- RESET_STATE, 2'b00, state loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low; sampled only on the rising edge of clk
- in  input  1  serial data bit
- in_valid  input  1  `in` is consumed on this edge only when high
- load  input  1  force the state register to `load_state`
- load_state  input  2  value used by `load`
- clr_count  input  1  synchronous clear of `det_count`
- currstate  output  2  registered present state
- nextstate  output  2  combinational next state for the current `in`, ignoring `in_valid` (observability only)
- detect  output  1  Moore output, high while `currstate` == 2'b11
- det_pulse  output  1  registered one-cycle pulse on each entry into 2'b11
- det_count  output  CNT_W  number of detections, saturating

Behaviour:
- States: S0=00 idle, S1=01 seen "1", S2=10 seen "10", S3=11 seen "101".
- Transitions (in=0 / in=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S1 (overlap kept)
- `nextstate` is always the table value for (`currstate`, `in`).
- Update priority at each rising edge: `rst_n`=0 > `load`=1 > `in_valid`=1 > hold.
- Reset (`rst_n` low at an edge):
  - `currstate`=RESET_STATE, `det_pulse`=0, `det_count`=0.
  - `detect` follows the reset state.
  - Reset mid-sequence discards all history; there is no asynchronous effect between edges.
- Load: `currstate`<=`load_state`.
  - `det_pulse`=0 and `det_count` unchanged, even when `load_state`=11.
  - `in`/`in_valid` are ignored that cycle.
- Step (`in_valid`=1, no load): `currstate`<=`nextstate`.
  - If the new state is S3 and the old state is not S3, `det_pulse`<=1 that same edge and `det_count` increments.
  - Otherwise `det_pulse`<=0.
- Hold (`in_valid`=0): state unchanged, `det_pulse`<=0.
  - `detect` stays high if holding in S3; the pulse does not repeat.
- Latency: a bit accepted at edge k is reflected in `currstate`/`detect`/`det_pulse` immediately after edge k (one cycle). There is no combinational path from `in` to `detect`.
- Counter:
  - Increments by 1 per detection.
  - Saturates at 2^CNT_W-1 (no wrap).
  - `clr_count`=1 forces 0 and wins over a simultaneous detection, so count=0 while `det_pulse` still =1.
  - `clr_count` is ignored during reset; the result is 0 either way.
- S3 cannot self-loop, so back-to-back detections need at least 2 accepted bits between them (e.g. "10101" gives 2 hits).
- No X propagation: every output has a defined value after the first reset edge.

Test Plan:
- Reset: `rst_n`=0 for 2 edges, then 1 -> `currstate`=00, `detect`=0, `det_pulse`=0, `det_count`=0.
- Overlap: `in_valid`=1, bits 1,0,1,0,1 on consecutive edges -> `currstate` sequence 01,10,11,10,11; `det_pulse` high after edges 3 and 5; `det_count`=2.
- Gating: send 1,0, drop `in_valid` for 3 cycles with `in` toggling, then send 1 -> state holds 10 during the gap, then goes to 11; exactly one `det_pulse`; `det_count`=1.
- Load and priority: `load`=1, `load_state`=11, `in_valid`=1, `in`=0 -> `currstate`=11, `detect`=1, `det_pulse`=0, count unchanged. Next bit `in`=1 -> 01.
- Counter boundary: CNT_W=2, force 4 detections -> `det_count` 1,2,3,3. Assert `clr_count` on the edge of a 5th detection -> count=0, `det_pulse`=1.
- Reset mid-run: in S2 with `det_count`=5, assert `rst_n`=0 for one edge alongside `in`=1, `in_valid`=1 -> `currstate`=00, count=0, no `det_pulse`.
